// File: rtl/fetch_unit.sv
// Fetch unit: consumer side of the PC interface. Issues in-order fetches to
// instruction memory, tags each response with its PC, buffers the fetched
// words and hands them to decode over a valid/ready handshake. A redirect
// flushes the buffer and marks all older in-flight fetches as stale.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        stall,
  input  logic        redirect,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } q_entry_t;

  // Synchronised reset release
  logic [1:0] rst_sync;
  logic       out_of_reset;

  // Occupancy counters and ring pointers
  logic [CW-1:0] q_cnt, live_cnt, kill_cnt;
  logic [PW-1:0] q_wr, q_rd, t_wr, t_rd;
  logic [CW:0]   occupancy;
  logic [CW:0]   outstanding;

  // Storage
  q_entry_t    q_mem   [DEPTH];
  logic [31:0] tag_mem [DEPTH];

  // Per-cycle events
  logic req_fire;
  logic resp_any;
  logic resp_kill;
  logic resp_take;
  logic pop;
  logic first_pending;
  logic unused_pc_bits;

  assign unused_pc_bits = ^pc_in[1:0];

  // Two-stage synchroniser so issue starts cleanly after reset release
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign out_of_reset = rst_sync[1];

  assign occupancy   = (CW+1)'(q_cnt) + (CW+1)'(live_cnt);
  assign outstanding = (CW+1)'(kill_cnt) + (CW+1)'(live_cnt);

  assign imem_req_valid = out_of_reset && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = {pc_in[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign stall          = !req_fire;

  assign inst_valid = (q_cnt != '0);
  assign inst       = inst_valid ? q_mem[q_rd].word : 32'h0;
  assign inst_pc    = inst_valid ? q_mem[q_rd].pc   : 32'h0;

  // Classify this cycle's response and pop; a redirect discards both
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    resp_any  = 1'b0;
    resp_kill = 1'b0;
    resp_take = 1'b0;
    pop       = 1'b0;
    if (imem_resp_valid && (outstanding != '0)) begin
      resp_any  = 1'b1;
      resp_kill = (kill_cnt != '0);
      resp_take = (kill_cnt == '0) && !redirect;
    end
    pop = inst_valid && inst_ready && !redirect;
  end

  // Counters and pointers; redirect flushes the queue and turns live fetches stale
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_cnt    <= '0;
      live_cnt <= '0;
      kill_cnt <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      t_wr     <= '0;
      t_rd     <= '0;
    end else if (redirect) begin
      q_cnt    <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      kill_cnt <= kill_cnt + live_cnt - CW'(resp_any);
      live_cnt <= CW'(req_fire);
      t_rd     <= t_wr;
      t_wr     <= t_wr + PW'(req_fire);
    end else begin
      kill_cnt <= kill_cnt - CW'(resp_kill);
      live_cnt <= live_cnt + CW'(req_fire) - CW'(resp_take);
      q_cnt    <= q_cnt + CW'(resp_take) - CW'(pop);
      q_wr     <= q_wr + PW'(resp_take);
      q_rd     <= q_rd + PW'(pop);
      t_wr     <= t_wr + PW'(req_fire);
      t_rd     <= t_rd + PW'(resp_take);
    end
  end

  // Tag and instruction storage writes
  // NOTE: storage arrays carry no reset; validity lives in the counters and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (req_fire)  tag_mem[t_wr] <= imem_req_addr;
    if (resp_take) q_mem[q_wr]   <= '{pc: tag_mem[t_rd], word: imem_resp_data};
  end

  // Tracks whether the first fetch since reset is still to be accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        first_pending <= 1'b1;
    else if (req_fire) first_pending <= 1'b0;
  end

  // A response with nothing outstanding is a memory protocol error
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (outstanding != '0));

  a_occupancy_bound: assert property (@(posedge clk) disable iff (!reset)
    occupancy <= (CW+1)'(DEPTH));

  a_kill_bound: assert property (@(posedge clk) disable iff (!reset)
    kill_cnt <= CW'(DEPTH));

  a_first_fetch_addr: assert property (@(posedge clk) disable iff (!reset)
    (req_fire && first_pending) |-> (imem_req_addr == PC_RESET));

endmodule
